// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the MINA core.
// Produces per-stage enable/flush controls, resolves load-use, redirect,
// fetch-wait and memory-wait priorities, sequences HALT through a drain
// window into HALTED, and keeps saturating stall/flush counters.
module pipe_ctrl #(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  // One bundle for every stage control so each pipeline situation is a
  // single named constant rather than six scattered assignments.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
  } ctrl_t;

  // Drain counter holds DRAIN_CYCLES-1 down to 0.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Everything frozen: memory wait and HALTED.
  localparam ctrl_t C_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                 id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0};
  // Normal advance of every stage.
  localparam ctrl_t C_ADV    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                 id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1};
  // Taken redirect: load target PC, kill the two younger instructions.
  localparam ctrl_t C_REDIR  = '{pc_en: 1'b1, if_id_en: 1'b0, if_id_flush: 1'b1,
                                 id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b1};
  // Load-use: hold PC and ID, insert a bubble into EX, let the load move on.
  localparam ctrl_t C_LDUSE  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                 id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b1};
  // Fetch wait / drain: hold PC, bubble into ID, older stages keep moving.
  localparam ctrl_t C_BUBID  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                 id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1};
  // HALT in ID: HALT advances into EX, nothing new is fetched behind it.
  localparam ctrl_t C_HALTID = '{pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1,
                                 id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1};
  // Reset: registers load bubbles, nothing is enabled.
  localparam ctrl_t C_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                 id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b0};

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic  mem_wait;
  logic  rs1_hit, rs2_hit;
  logic  load_use;
  logic  redir_take;
  logic  stall_cyc;
  ctrl_t ctrl;

  assign mem_wait = dmem_req & ~dmem_ready;

  // Register 0 is hardwired zero, so a load to it never creates a hazard.
  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
  assign load_use = ex_valid & ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);

  // Priority resolution of the stage controls and next-state selection.
  always_comb begin
    ctrl       = C_FREEZE;
    state_d    = state_q;
    drain_d    = drain_q;
    redir_take = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          // A held redirect is simply re-presented once the wait ends.
          ctrl = C_FREEZE;
        end else if (ex_redirect) begin
          ctrl       = C_REDIR;
          redir_take = 1'b1;
        end else if (load_use) begin
          ctrl = C_LDUSE;
        end else if (!imem_ready) begin
          ctrl = C_BUBID;
        end else if (id_halt) begin
          ctrl    = C_HALTID;
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          ctrl = C_ADV;
        end
      end
      S_DRAIN: begin
        if (mem_wait) begin
          ctrl = C_FREEZE;
        end else if (ex_redirect) begin
          // HALT was fetched down a mispredicted path; resume at the target.
          ctrl       = C_REDIR;
          redir_take = 1'b1;
          state_d    = S_RUN;
        end else begin
          ctrl = C_BUBID;
          if (drain_q == '0) begin
            state_d = S_HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      S_HALTED: begin
        ctrl = C_FREEZE;
        if (resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    // Outputs present the reset pattern while reset is held.
    if (!rst_n) begin
      ctrl = C_RESET;
    end
  end

  assign stall_cyc = (state_q == S_RUN) & ~ctrl.pc_en;

  // Sequencer state and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating performance counters; they stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_cyc && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redir_take && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign halted      = rst_n & (state_q == S_HALTED);
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Control outputs are compared as a 7-bit
// vector {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
// halted}; counters are compared after the clock edge that updates them.
module tb_pipe_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used, id_halt;
  logic             ex_valid, ex_is_load, ex_redirect;
  logic             imem_ready, dmem_req, dmem_ready, resume;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected control vectors
  localparam logic [6:0] V_RESET  = 7'b0010100;
  localparam logic [6:0] V_ADV    = 7'b1101010;
  localparam logic [6:0] V_LDUSE  = 7'b0000110;
  localparam logic [6:0] V_REDIR  = 7'b1010110;
  localparam logic [6:0] V_BUBID  = 7'b0011010;
  localparam logic [6:0] V_HALTID = 7'b0111010;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_HALTED = 7'b0000001;

  logic [6:0] ctl;
  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, halted};

  pipe_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_halt(id_halt), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_halt = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; resume = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("reset_ctl", 32'(ctl), 32'(V_RESET));
    chk("reset_stall", 32'(stall_count), 0);
    chk("reset_flush", 32'(flush_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("run_adv", 32'(ctl), 32'(V_ADV));
    tick();

    // Load-use via rs2: one bubble, then full advance
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    #1 chk("lduse_ctl", 32'(ctl), 32'(V_LDUSE));
    tick();
    ex_valid = 1'b0;
    #1 chk("lduse_release", 32'(ctl), 32'(V_ADV));
    chk("lduse_stall", 32'(stall_count), 1);
    tick();

    // Load to x0 never hazards
    idle_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1 chk("x0_no_stall", 32'(ctl), 32'(V_ADV));
    tick();
    chk("x0_stall_cnt", 32'(stall_count), 1);
    // Matching rs1 that is not actually read
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0;
    #1 chk("unused_rs_no_stall", 32'(ctl), 32'(V_ADV));
    tick();

    // Redirect beats load-use and fetch wait
    idle_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    imem_ready = 1'b0; ex_redirect = 1'b1;
    #1 chk("redir_prio_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    chk("redir_flush_cnt", 32'(flush_count), 1);
    chk("redir_stall_cnt", 32'(stall_count), 1);

    // Fetch wait alone
    idle_inputs();
    imem_ready = 1'b0;
    #1 chk("imem_wait_ctl", 32'(ctl), 32'(V_BUBID));
    tick();
    chk("imem_wait_stall", 32'(stall_count), 2);

    // Memory wait with held redirect, 4 cycles, then redirect taken
    idle_inputs();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("memwait_ctl_%0d", i), 32'(ctl), 32'(V_FREEZE));
      tick();
    end
    chk("memwait_stall", 32'(stall_count), 6);
    chk("memwait_no_flush", 32'(flush_count), 1);
    dmem_ready = 1'b1;
    #1 chk("memwait_release_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    chk("memwait_flush", 32'(flush_count), 2);

    // HALT, drain with one mem-wait freeze in the middle, then HALTED
    idle_inputs();
    id_halt = 1'b1;
    #1 chk("halt_id_ctl", 32'(ctl), 32'(V_HALTID));
    tick();
    chk("halt_id_stall", 32'(stall_count), 7);
    id_halt = 1'b0;
    #1 chk("drain1_ctl", 32'(ctl), 32'(V_BUBID));
    tick();
    dmem_req = 1'b1;
    #1 chk("drain_freeze_ctl", 32'(ctl), 32'(V_FREEZE));
    tick();
    dmem_req = 1'b0;
    #1 chk("drain2_ctl", 32'(ctl), 32'(V_BUBID));
    tick();
    #1 chk("drain3_ctl", 32'(ctl), 32'(V_BUBID));
    tick();
    #1 chk("halted_ctl", 32'(ctl), 32'(V_HALTED));
    chk("drain_stall_hold", 32'(stall_count), 7);
    ex_redirect = 1'b1; id_halt = 1'b1; imem_ready = 1'b0;
    tick();
    #1 chk("halted_ignores", 32'(ctl), 32'(V_HALTED));
    chk("halted_flush_hold", 32'(flush_count), 2);
    idle_inputs();
    resume = 1'b1;
    #1 chk("resume_cycle_ctl", 32'(ctl), 32'(V_HALTED));
    tick();
    resume = 1'b0;
    #1 chk("after_resume_ctl", 32'(ctl), 32'(V_ADV));
    tick();

    // HALT on wrong path: redirect in first drain cycle
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; ex_redirect = 1'b1;
    #1 chk("drain_redir_ctl", 32'(ctl), 32'(V_REDIR));
    tick();
    ex_redirect = 1'b0;
    #1 chk("drain_redir_run", 32'(ctl), 32'(V_ADV));
    chk("drain_redir_flush", 32'(flush_count), 3);
    chk("drain_redir_stall", 32'(stall_count), 8);
    tick();

    // HALT to HALTED, then async reset pulse
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    tick(); tick(); tick();
    #1 chk("halted_again", 32'(ctl), 32'(V_HALTED));
    #2 rst_n = 1'b0;
    #1 chk("rst_halted_ctl", 32'(ctl), 32'(V_RESET));
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_flush", 32'(flush_count), 0);
    #1 rst_n = 1'b1;
    #1 chk("post_rst_run", 32'(ctl), 32'(V_ADV));
    tick();

    // Counter saturation at 4 bits
    imem_ready = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("stall_saturate", 32'(stall_count), 15);
    imem_ready = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("flush_saturate", 32'(flush_count), 15);
    chk("stall_sat_hold", 32'(stall_count), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
